spi_frame_tx: RTL and testbench

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_frame_pack.sv | 35 +++
 rtl/spi_frame_tx.sv | 118 +++++++++++
 tb/tb_spi_frame_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame transmitter and its matching receiver.
package spi_pkg;

  localparam int FRAME_BITS    = 64;
  localparam int PAYLOAD_WORDS = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Field order is the on-wire order, MSB first.
  typedef struct packed {
    logic signed [15:0] word0;
    logic signed [15:0] word1;
    logic signed [15:0] word2;
    logic        [7:0]  seq;
    logic        [7:0]  xsum;
  } frame_t;

endpackage

// File: rtl/spi_frame_pack.sv
// Builds one frame from the payload words and a sequence number.
// The checksum is the XOR of all payload bytes.
module spi_frame_pack
  import spi_pkg::*;
(
  input  logic signed [15:0] word0,
  input  logic signed [15:0] word1,
  input  logic signed [15:0] word2,
  input  logic        [7:0]  seq,
  output frame_t             frame
);

  logic [15:0] words [PAYLOAD_WORDS];
  logic [7:0]  xsum;

  assign words[0] = word0;
  assign words[1] = word1;
  assign words[2] = word2;

  always_comb begin
    xsum = 8'h00;
    for (int i = 0; i < PAYLOAD_WORDS; i++) begin
      xsum = xsum ^ words[i][15:8] ^ words[i][7:0];
    end
  end

  always_comb begin
    frame.word0 = word0;
    frame.word1 = word1;
    frame.word2 = word2;
    frame.seq   = seq;
    frame.xsum  = xsum;
  end

endmodule

// File: rtl/spi_frame_tx.sv
// SPI slave-side frame transmitter: one-entry pending buffer feeding a
// shift register clocked by the controller's sclk, MSB first.
module spi_frame_tx #(
  parameter int FRAME_BITS = spi_pkg::FRAME_BITS
) (
  input  logic               sclk,
  input  logic               resetn,
  input  logic               cs_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_word0,
  input  logic signed [15:0] in_word1,
  input  logic signed [15:0] in_word2,
  output logic               sdo,
  output logic               sdo_oe,
  output logic               frame_done,
  output logic               busy,
  output logic        [7:0]  abort_cnt
);

  import spi_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  frame_t                frame_buf;
  frame_t                next_frame;
  frame_t                reload_frame;
  logic signed [15:0]    pend_word0;
  logic signed [15:0]    pend_word1;
  logic signed [15:0]    pend_word2;
  logic                  pend_valid;
  logic [7:0]            next_seq;
  state_t                state;
  logic                  last_bit;
  logic                  reload;
  logic                  take;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // The frame sits in the top bits; any extra FRAME_BITS beyond it shift out as 0.
  function automatic logic [FRAME_BITS-1:0] align(input frame_t f);
    logic [FRAME_BITS-1:0] v;
    v = '0;
    v[FRAME_BITS-1 -: $bits(frame_t)] = f;
    return v;
  endfunction

  assign state    = cs_n ? IDLE : SHIFT;
  assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign reload   = (state == IDLE) || last_bit;
  assign take     = in_valid && in_ready;
  assign next_seq = frame_buf.seq + 8'd1;

  assign in_ready = ~pend_valid;
  assign sdo      = shift_reg[FRAME_BITS-1];
  assign sdo_oe   = ~cs_n;
  assign busy     = (bit_cnt != '0);

  spi_frame_pack u_pack (
    .word0 (pend_word0),
    .word1 (pend_word1),
    .word2 (pend_word2),
    .seq   (next_seq),
    .frame (next_frame)
  );

  // Without a pending entry the last committed frame is resent with its old seq.
  assign reload_frame = pend_valid ? next_frame : frame_buf;

  always_ff @(posedge sclk) begin
    if (take) begin
      pend_word0 <= in_word0;
      pend_word1 <= in_word1;
      pend_word2 <= in_word2;
    end
  end

  always_ff @(posedge sclk) begin
    if (!resetn) begin
      shift_reg  <= '0;
      frame_buf  <= '0;
      pend_valid <= 1'b0;
      bit_cnt    <= '0;
      abort_cnt  <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (take) begin
        pend_valid <= 1'b1;
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (bit_cnt != '0) begin
          abort_cnt <= sat_inc(abort_cnt);
        end
      end else if (last_bit) begin
        bit_cnt    <= '0;
        frame_done <= 1'b1;
      end else begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= shift_reg << 1;
      end
      // take needs an empty buffer, so it never collides with this clear.
      if (reload) begin
        shift_reg <= align(reload_frame);
        if (pend_valid) begin
          frame_buf  <= next_frame;
          pend_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: directed scenarios plus random traffic
// against a frame/bit-position reference model.
module tb_spi_frame_tx;

  logic        sclk = 1'b0;
  logic        resetn = 1'b0;
  logic        cs_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_word0 = '0;
  logic [15:0] in_word1 = '0;
  logic [15:0] in_word2 = '0;
  logic        sdo;
  logic        sdo_oe;
  logic        frame_done;
  logic        busy;
  logic [7:0]  abort_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current frame on the wire and the index of the next bit.
  logic [63:0] m_cur;
  logic [15:0] m_w0, m_w1, m_w2;
  logic [7:0]  m_seq;
  logic [15:0] m_p0, m_p1, m_p2;
  bit          m_pv;
  int          m_pos;
  int          m_abort;
  bit          m_done;

  spi_frame_tx #(.FRAME_BITS(64)) dut (
    .sclk       (sclk),
    .resetn     (resetn),
    .cs_n       (cs_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word0   (in_word0),
    .in_word1   (in_word1),
    .in_word2   (in_word2),
    .sdo        (sdo),
    .sdo_oe     (sdo_oe),
    .frame_done (frame_done),
    .busy       (busy),
    .abort_cnt  (abort_cnt)
  );

  always #5 sclk = ~sclk;

  function automatic logic [63:0] make_frame(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [7:0] s);
    logic [47:0] p;
    logic [7:0]  x;
    p = {a, b, c};
    x = 8'h00;
    for (int i = 0; i < 6; i++) x = x ^ p[i*8 +: 8];
    return {p, s, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic cs, input logic v,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    bit hs, rl;
    if (!rn) begin
      m_cur = '0; m_w0 = '0; m_w1 = '0; m_w2 = '0; m_seq = '0;
      m_pv = 0; m_pos = 0; m_abort = 0; m_done = 0;
      return;
    end
    hs = v && !m_pv;
    rl = cs || (m_pos == 63);
    m_done = !cs && (m_pos == 63);
    if (cs && m_pos != 0 && m_abort < 255) m_abort++;
    m_pos = (!cs && m_pos != 63) ? m_pos + 1 : 0;
    if (rl) begin
      if (m_pv) begin
        m_w0 = m_p0; m_w1 = m_p1; m_w2 = m_p2;
        m_seq = m_seq + 8'd1;
        m_pv = 0;
      end
      m_cur = make_frame(m_w0, m_w1, m_w2, m_seq);
    end
    if (hs) begin
      m_p0 = a; m_p1 = b; m_p2 = c; m_pv = 1;
    end
  endtask

  task automatic step(input logic rn, input logic cs, input logic v,
                      input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    resetn = rn; cs_n = cs; in_valid = v;
    in_word0 = a; in_word1 = b; in_word2 = c;
    @(posedge sclk);
    model_edge(rn, cs, v, a, b, c);
    #1;
    chk("sdo", 64'(sdo), 64'(m_cur[63 - m_pos]));
    chk("sdo_oe", 64'(sdo_oe), 64'(!cs));
    chk("in_ready", 64'(in_ready), 64'(!m_pv));
    chk("busy", 64'(busy), 64'(m_pos != 0));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("abort_cnt", 64'(abort_cnt), 64'(m_abort));
  endtask

  task automatic shift_idle();
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic capture64(output logic [63:0] s);
    s = '0;
    for (int i = 0; i < 64; i++) begin
      s = {s[62:0], sdo};
      shift_idle();
    end
  endtask

  initial begin
    logic [63:0]  s64;
    logic [127:0] s128;
    int           dones;

    m_pos = 0; m_pv = 0;
    #1;
    step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("reset_sdo", 64'(sdo), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // 64 shift edges with nothing loaded: zeros and a single frame_done at edge 64
    dones = 0;
    s64 = '1;
    for (int i = 0; i < 64; i++) begin
      s64 = {s64[62:0], sdo};
      shift_idle();
      if (frame_done) dones++;
      if (i == 63) chk("done_at_64", 64'(frame_done), 64'd1);
    end
    chk("empty_stream", s64, 64'd0);
    chk("done_count", 64'(dones), 64'd1);

    // First load, committed on an IDLE edge
    step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h8000, 16'h00FF);
    chk("ready_after_take", 64'(in_ready), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    capture64(s64);
    chk("frame1", s64, 64'h1234_8000_00FF_0159);

    // Stale resend keeps seq
    capture64(s64);
    chk("frame1_again", s64, 64'h1234_8000_00FF_0159);

    // Abort after 20 bits, then restart from bit 63 of the same data
    for (int i = 0; i < 20; i++) shift_idle();
    step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("abort_one", 64'(abort_cnt), 64'd1);
    capture64(s64);
    chk("frame_after_abort", s64, 64'h1234_8000_00FF_0159);

    // 128 continuous edges with a new load offered mid-frame
    s128 = '0;
    for (int i = 0; i < 128; i++) begin
      s128 = {s128[126:0], sdo};
      step(1'b1, 1'b0, (i == 30), 16'hA5A5, 16'h0F0F, 16'h7FFF);
      if (i == 62) chk("ready_before_reload", 64'(in_ready), 64'd0);
      if (i == 63) chk("ready_after_reload", 64'(in_ready), 64'd1);
    end
    chk("b2b_first", s128[127:64], 64'h1234_8000_00FF_0159);
    chk("b2b_second", s128[63:0], 64'hA5A5_0F0F_7FFF_0280);

    // Reset mid-frame with a pending entry held
    step(1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 29; i++) shift_idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("rst_mid_sdo", 64'(sdo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_abort", 64'(abort_cnt), 64'd0);

    // Abort counter saturation
    for (int i = 0; i < 260; i++) begin
      shift_idle();
      step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    end
    chk("abort_sat", 64'(abort_cnt), 64'd255);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
